// File: rtl/udcnt10_timer_ctrl.sv
// Sequencer for a loadable up/down decade counter: loads a preset digit, then
// steps the counter every PRESCALE clocks until its output reaches a target digit.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for START; validates and latches preset/target/dir
// S_LOAD | one-cycle counter load, prescaler cleared
// S_RUN  | prescaled stepping until counter output matches target
// S_DONE | one-cycle completion pulse
module udcnt10_timer_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] preset,
  input  logic [3:0] target,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] cnt_q,
  output logic       cnt_load,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic [3:0] cnt_in,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [3:0]      preset_q, preset_d;
  logic [3:0]      target_q, target_d;
  logic            dir_q, dir_d;
  logic            err_q, err_d;
  logic            match, q_bad, ps_last, start_ok;

  assign match    = (cnt_q == target_q);
  assign q_bad    = (cnt_q > 4'd9);
  assign ps_last  = (ps_q == PS_LAST);
  assign start_ok = (preset <= 4'd9) && (target <= 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ps_q     <= '0;
      preset_q <= 4'd0;
      target_q <= 4'd0;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ps_q     <= ps_d;
      preset_q <= preset_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ps_d     = ps_q;
    preset_d = preset_q;
    target_d = target_q;
    dir_d    = dir_q;
    err_d    = err_q;
    cnt_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            preset_d = preset;
            target_d = target;
            dir_d    = dir;
            err_d    = 1'b0;
            state_d  = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        ps_d    = '0;
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // abort outranks a corrupted counter readback, which outranks match
        if (abort) begin
          state_d = S_IDLE;
        end else if (q_bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (match) begin
          state_d = S_DONE;
        end else if (!pause) begin
          ps_d   = ps_last ? '0 : ps_q + PS_W'(1);
          cnt_en = ps_last;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_load = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign cnt_up   = dir_q;
  assign cnt_in   = preset_q;
  assign err      = err_q;

endmodule

// File: tb/tb_udcnt10_timer_ctrl.sv
// Bench for udcnt10_timer_ctrl: a behavioural decade counter closes the loop, and
// a scoreboard of expected LOAD/EN/DONE events is checked by a separate monitor.
module tb_udcnt10_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] preset = 4'd0;
  logic [3:0] target = 4'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cnt_q;
  logic       cnt_load, cnt_en, cnt_up, busy, done, err;
  logic [3:0] cnt_in;

  logic [3:0] q_m = 4'd0;
  logic       force_bad = 1'b0;

  int cc = 0;
  int s = 0;
  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {int kind; int cyc; int val;} ev_t;
  ev_t exp_q[$];

  udcnt10_timer_ctrl #(.PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .preset(preset),
    .target(target), .pause(pause), .abort(abort), .cnt_q(cnt_q),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_in(cnt_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cc <= cc + 1;

  // LD_EN_UDCNT10 model: load beats enable, wraps 9->0 up and 0->9 down
  always @(posedge clk) begin
    if (cnt_load) q_m <= cnt_in;
    else if (cnt_en) q_m <= cnt_up ? ((q_m == 4'd9) ? 4'd0 : q_m + 4'd1)
                                   : ((q_m == 4'd0) ? 4'd9 : q_m - 4'd1);
  end
  assign cnt_q = force_bad ? 4'hB : q_m;

  function automatic string kname(int k);
    case (k)
      0: return "load";
      1: return "en";
      default: return "done";
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cc - s);
    end
  endtask

  task automatic mon_ev(int kind, int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL spurious_%s: got event at cycle %0d, expected none", kname(kind), cc - s);
    end else begin
      e = exp_q.pop_front();
      check({"kind_", kname(e.kind)}, kind, e.kind);
      check({"cycle_", kname(e.kind)}, cc - s, e.cyc);
      check({"value_", kname(e.kind)}, val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cnt_load) mon_ev(0, int'(cnt_in));
      if (cnt_en)   mon_ev(1, int'(cnt_q));
      if (done)     mon_ev(2, int'(cnt_q));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(int c);
    int guard = 0;
    while (cc < s + c && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  task automatic ex(int k, int c, int v);
    exp_q.push_back('{k, c, v});
  endtask

  task automatic do_start(int p, int t, logic d);
    preset = 4'(p);
    target = 4'(t);
    dir    = d;
    start  = 1'b1;
    s      = cc;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_busy_end"}, int'(busy), 0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_load", int'(cnt_load), 0);
    check("rst_en", int'(cnt_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_in", int'(cnt_in), 0);
    check("rst_up", int'(cnt_up), 1);
    reset = 1'b0;
    tick();

    // up 3->7: N=4
    ex(0, 1, 3); ex(1, 5, 3); ex(1, 9, 4); ex(1, 13, 5); ex(1, 17, 6); ex(2, 19, 7);
    do_start(3, 7, 1'b1);
    check("up_busy_load", int'(busy), 1);
    check("up_dir", int'(cnt_up), 1);
    wait_done("up");

    // down 2->8 wrapping through 0: N=4
    ex(0, 1, 2); ex(1, 5, 2); ex(1, 9, 1); ex(1, 13, 0); ex(1, 17, 9); ex(2, 19, 8);
    do_start(2, 8, 1'b0);
    check("down_dir", int'(cnt_up), 0);
    wait_done("down");

    // up 8->1 wrapping through 9: N=3
    ex(0, 1, 8); ex(1, 5, 8); ex(1, 9, 9); ex(1, 13, 0); ex(2, 15, 1);
    do_start(8, 1, 1'b1);
    wait_done("upwrap");

    // zero steps
    ex(0, 1, 5); ex(2, 3, 5);
    do_start(5, 5, 1'b1);
    wait_done("zero");

    // pause cycles 7..12
    ex(0, 1, 3); ex(1, 5, 3); ex(1, 15, 4); ex(1, 19, 5); ex(1, 23, 6); ex(2, 25, 7);
    do_start(3, 7, 1'b1);
    go(7);
    pause = 1'b1;
    go(13);
    pause = 1'b0;
    wait_done("pause");

    // out-of-range start requests
    do_start(12, 7, 1'b0);
    check("badp_err", int'(err), 1);
    check("badp_busy", int'(busy), 0);
    check("badp_in_kept", int'(cnt_in), 3);
    do_start(4, 10, 1'b0);
    check("badt_err", int'(err), 1);
    check("badt_up_kept", int'(cnt_up), 1);
    wait_done("bad");

    // abort at cycle 10
    ex(0, 1, 3); ex(1, 5, 3); ex(1, 9, 4);
    do_start(3, 7, 1'b1);
    check("abort_err_clr", int'(err), 0);
    go(10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    wait_done("abort");

    // corrupted counter readback during RUN
    ex(0, 1, 3);
    do_start(3, 7, 1'b1);
    go(3);
    force_bad = 1'b1;
    tick();
    force_bad = 1'b0;
    check("qbad_err", int'(err), 1);
    check("qbad_busy", int'(busy), 0);
    wait_done("qbad");

    // valid start clears sticky error
    ex(0, 1, 5); ex(2, 3, 5);
    do_start(5, 5, 1'b1);
    check("clr_err", int'(err), 0);
    wait_done("clr");

    // reset clears error in idle
    do_start(9, 12, 1'b1);
    check("pre_rst_err", int'(err), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("idle_rst_err", int'(err), 0);
    tick();

    // reset mid-run at cycle 6 of a down sequence
    ex(0, 1, 3); ex(1, 5, 3);
    do_start(3, 7, 1'b0);
    go(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_en", int'(cnt_en), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_err", int'(err), 0);
    check("mrst_in", int'(cnt_in), 0);
    check("mrst_up", int'(cnt_up), 1);
    repeat (20) tick();
    wait_done("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
